div_iter: RTL and testbench

//  Multi-cycle iterative RV64M divider in the execute stage, beside the single-cycle alu.

---
 rtl/decode_pkg.sv | 22 ++
 rtl/div_iter.sv | 192 +++++++++++++++++++
 tb/tb_div_iter.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// ============================================================================
// Module   : decode_pkg
// Purpose  : Divider function encoding and iteration counts shared by execute.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package decode_pkg;

  typedef enum logic [1:0] {
    DIV_DIV  = 2'd0,
    DIV_DIVU = 2'd1,
    DIV_REM  = 2'd2,
    DIV_REMU = 2'd3
  } divfunc_t;

  localparam int DIV_ITER64 = 64;
  localparam int DIV_ITER32 = 32;

endpackage

`default_nettype wire

// File: rtl/div_iter.sv
// ============================================================================
// Module   : div_iter
// Purpose  : Iterative radix-2 restoring RV64M divider (DIV/DIVU/REM/REMU + W).
//            Optional build macro DIV_EARLY_OUT_EN: trivial cases finish at accept.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_iter
  import decode_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [1:0]      divfunc,
  input  logic            is_32instr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] c
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_iter_state_t;

  div_iter_state_t state, state_nx;

  logic [XLEN-1:0] quo, rem, dvs;
  logic [5:0]      cnt;
  logic            q_neg, r_neg, sel_rem, word;

  logic            is_signed, rem_sel, a_neg, b_neg, b_zero, accept, early_out;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag;

  // W forms see only the low word, extended according to signedness.
  always_comb begin
    is_signed = (divfunc == DIV_DIV) || (divfunc == DIV_REM);
    rem_sel   = (divfunc == DIV_REM) || (divfunc == DIV_REMU);
    a_ext     = is_32instr ? {{(XLEN-32){is_signed & a[31]}}, a[31:0]} : a;
    b_ext     = is_32instr ? {{(XLEN-32){is_signed & b[31]}}, b[31:0]} : b;
    a_neg     = is_signed & a_ext[XLEN-1];
    b_neg     = is_signed & b_ext[XLEN-1];
    a_mag     = a_neg ? -a_ext : a_ext;
    b_mag     = b_neg ? -b_ext : b_ext;
    b_zero    = (b_ext == '0);
    accept    = in_valid & in_ready & ~flush;
  end

  logic [XLEN:0]   rem_sh, diff;
  logic            step_ge;
  logic [XLEN-1:0] rem_nx, quo_nx;

  always_comb begin
    rem_sh  = {rem, quo[XLEN-1]};
    diff    = rem_sh - {1'b0, dvs};
    step_ge = ~diff[XLEN];
    rem_nx  = step_ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_nx  = {quo[XLEN-2:0], step_ge};
  end

  logic [XLEN-1:0] fq_mag, fr_mag, q_fin, r_fin, res, fix_c;
  logic            fq_neg, fr_neg, fsel, fw;

`ifdef DIV_EARLY_OUT_EN
  logic [XLEN-1:0] min_mag;
  logic            ovf;

  always_comb begin
    min_mag   = is_32instr ? {{(XLEN-32){1'b0}}, 1'b1, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    ovf       = a_neg & (a_mag == min_mag) & is_signed & (b_ext == '1);
    early_out = b_zero | ovf | (a_mag < b_mag);
  end

  // In IDLE the fixup works on the short-circuit magnitudes instead of the iterator.
  always_comb begin
    if (state == IDLE) begin
      fq_mag = b_zero ? '1 : (ovf ? a_mag : '0);
      fr_mag = ovf ? '0 : a_mag;
      fq_neg = (a_neg ^ b_neg) & ~b_zero;
      fr_neg = a_neg;
      fsel   = rem_sel;
      fw     = is_32instr;
    end else begin
      fq_mag = quo_nx;
      fr_mag = rem_nx;
      fq_neg = q_neg;
      fr_neg = r_neg;
      fsel   = sel_rem;
      fw     = word;
    end
  end
`else
  always_comb begin
    early_out = 1'b0;
    fq_mag    = quo_nx;
    fr_mag    = rem_nx;
    fq_neg    = q_neg;
    fr_neg    = r_neg;
    fsel      = sel_rem;
    fw        = word;
  end
`endif

  // Division by zero naturally yields all-ones magnitude; q_neg is masked so it stays -1.
  always_comb begin
    q_fin = fq_neg ? -fq_mag : fq_mag;
    r_fin = fr_neg ? -fr_mag : fr_mag;
    res   = fsel ? r_fin : q_fin;
    fix_c = fw ? {{(XLEN-32){res[31]}}, res[31:0]} : res;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !flush) begin
          state_nx = early_out ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (flush) begin
          state_nx = IDLE;
        end else if (cnt == '0) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (flush || out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      quo     <= '0;
      rem     <= '0;
      dvs     <= '0;
      cnt     <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      sel_rem <= 1'b0;
      word    <= 1'b0;
      c       <= '0;
    end else if (accept) begin
      // W dividends are left-aligned so the iterator always shifts out of the MSB.
      quo     <= is_32instr ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;
      rem     <= '0;
      dvs     <= b_mag;
      cnt     <= is_32instr ? 6'(DIV_ITER32 - 1) : 6'(DIV_ITER64 - 1);
      q_neg   <= (a_neg ^ b_neg) & ~b_zero;
      r_neg   <= a_neg;
      sel_rem <= rem_sel;
      word    <= is_32instr;
      if (early_out) begin
        c <= fix_c;
      end
    end else if (state == BUSY && !flush) begin
      quo <= quo_nx;
      rem <= rem_nx;
      cnt <= cnt - 6'd1;
      if (cnt == '0) begin
        c <= fix_c;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div_iter.sv
// ============================================================================
// Module   : tb_div_iter
// Purpose  : Scoreboard bench for div_iter; latency counted in edges after accept.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_iter;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a, b, c;
  logic [1:0]  divfunc;
  logic        is_32instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int fails  = 0;
  logic [63:0] exp_q[$];

  div_iter #(.XLEN(64)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .divfunc(divfunc), .is_32instr(is_32instr), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .c(c)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [63:0] x, input logic [63:0] y,
                                        input divfunc_t f, input logic w);
    logic sg, rs;
    logic [63:0] q, r, res;
    logic signed [63:0] sx, sy;
    logic signed [31:0] sx32, sy32, q32, r32;
    sg = (f == DIV_DIV) || (f == DIV_REM);
    rs = (f == DIV_REM) || (f == DIV_REMU);
    q = '0;
    r = '0;
    if (w) begin
      sx32 = x[31:0];
      sy32 = y[31:0];
      if (y[31:0] == 32'd0) begin
        q = '1;
        r[31:0] = x[31:0];
      end else if (sg && x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF) begin
        q[31:0] = x[31:0];
      end else if (sg) begin
        q32 = sx32 / sy32;
        r32 = sx32 % sy32;
        q[31:0] = q32;
        r[31:0] = r32;
      end else begin
        q[31:0] = x[31:0] / y[31:0];
        r[31:0] = x[31:0] % y[31:0];
      end
      res = rs ? r : q;
      return {{32{res[31]}}, res[31:0]};
    end
    sx = x;
    sy = y;
    if (y == 64'd0) begin
      q = '1;
      r = x;
    end else if (sg && x == 64'h8000_0000_0000_0000 && y == '1) begin
      q = x;
    end else if (sg) begin
      q = sx / sy;
      r = sx % sy;
    end else begin
      q = x / y;
      r = x % y;
    end
    return rs ? r : q;
  endfunction

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic issue(input logic [63:0] x, input logic [63:0] y, input divfunc_t f,
                       input logic w, input logic [63:0] expv);
    int guard = 0;
    while (!in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) begin
      checks++;
      fails++;
      $display("FAIL issue_timeout: in_ready=%0b required 1", in_ready);
    end
    a = x;
    b = y;
    divfunc = f;
    is_32instr = w;
    in_valid = 1'b1;
    exp_q.push_back(expv);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // exp_lat < 0 skips the latency check; hold = cycles with out_ready low while valid.
  task automatic collect(input int exp_lat, input int hold, input string name);
    int lat = 0;
    logic busy_rdy = 1'b0;
    logic [63:0] expv;
    while (!out_valid && lat < 300) begin
      if (in_ready) busy_rdy = 1'b1;
      @(negedge clk);
      lat++;
    end
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
    checks++;
    if (!out_valid) begin
      fails++;
      $display("FAIL %s_timeout: out_valid=%0b required 1 within %0d cycles", name, out_valid, lat);
    end
    if (exp_lat >= 0) begin
      checks++;
      if (lat !== exp_lat) begin
        fails++;
        $display("FAIL %s_latency: got %0d required %0d", name, lat, exp_lat);
      end
    end
    checks++;
    if (busy_rdy !== 1'b0) begin
      fails++;
      $display("FAIL %s_busy_in_ready: in_ready seen 1 while busy, required 0", name);
    end
    checks++;
    if (c !== expv) begin
      fails++;
      $display("FAIL %s_result: c=%h required %h", name, c, expv);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || c !== expv) begin
        fails++;
        $display("FAIL %s_hold%0d: out_valid=%0b c=%h required 1 %h", name, i, out_valid, c, expv);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
    a = '0;
    b = '0;
    divfunc = DIV_DIV;
    is_32instr = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || c !== 64'd0) begin
      fails++;
      $display("FAIL reset_state: in_ready=%0b out_valid=%0b c=%h required 1 0 0", in_ready, out_valid, c);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    issue(64'd100, 64'd7, DIV_DIVU, 1'b0, 64'd14);
    collect(64, 0, "divu_100_7");
    issue(64'd100, 64'd7, DIV_REMU, 1'b0, 64'd2);
    collect(64, 0, "remu_100_7");
  endtask

  task automatic test_signed();
    issue(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, DIV_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD);
    collect(64, 0, "div_m7_2");
    issue(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, DIV_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    collect(64, 0, "rem_m7_2");
    issue(64'd7, 64'hFFFF_FFFF_FFFF_FFFE, DIV_REM, 1'b0, 64'd1);
    collect(64, 0, "rem_7_m2");
  endtask

  task automatic test_overflow();
    issue(64'h8000_0000_0000_0000, '1, DIV_DIV, 1'b0, 64'h8000_0000_0000_0000);
    collect(-1, 0, "div_ovf");
    issue(64'h8000_0000_0000_0000, '1, DIV_REM, 1'b0, 64'd0);
    collect(-1, 0, "rem_ovf");
  endtask

  task automatic test_div_zero();
    issue(64'd100, 64'd0, DIV_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    collect(-1, 0, "divu_zero");
    issue(64'd5, 64'd0, DIV_REMU, 1'b0, 64'd5);
    collect(-1, 0, "remu_zero");
    issue(64'hFFFF_FFFF_FFFF_FFF9, 64'd0, DIV_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    collect(-1, 0, "div_neg_zero");
    issue(64'hFFFF_FFFF_FFFF_FFF9, 64'd0, DIV_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9);
    collect(-1, 0, "rem_neg_zero");
  endtask

  task automatic test_word();
    issue(64'h0000_0000_FFFF_FFFF, 64'd1, DIV_DIVU, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    collect(32, 0, "divuw");
    issue(64'h0000_0000_FFFF_FFFF, 64'd2, DIV_REM, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    collect(32, 0, "remw");
    issue(64'hDEAD_0000_FFFF_FFF9, 64'h1234_0000_0000_0002, DIV_DIV, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD);
    collect(32, 0, "divw_upper");
    issue(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, DIV_DIV, 1'b1, 64'hFFFF_FFFF_8000_0000);
    collect(-1, 0, "divw_ovf");
    issue(64'h1111_1111_8000_0003, 64'h0, DIV_REMU, 1'b1, 64'hFFFF_FFFF_8000_0003);
    collect(-1, 0, "remuw_zero");
  endtask

  task automatic test_flush();
    logic seen = 1'b0;
    issue(64'd1000, 64'd3, DIV_DIV, 1'b0, 64'd333);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    void'(exp_q.pop_front());
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_busy: in_ready=%0b out_valid=%0b required 1 0", in_ready, out_valid);
    end
    for (int i = 0; i < 70; i++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL flush_no_valid: out_valid seen 1 required 0");
    end
    a = 64'd9;
    b = 64'd3;
    divfunc = DIV_DIV;
    is_32instr = 1'b0;
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_vs_valid: in_ready=%0b out_valid=%0b required 1 0", in_ready, out_valid);
    end
    issue(64'd9, 64'd3, DIV_DIV, 1'b0, 64'd3);
    collect(64, 0, "div_9_3_after_flush");
  endtask

  task automatic test_reset_midop();
    issue(64'd12345, 64'd11, DIV_REMU, 1'b0, 64'd3);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    void'(exp_q.pop_front());
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || c !== 64'd0) begin
      fails++;
      $display("FAIL reset_midop: in_ready=%0b out_valid=%0b c=%h required 1 0 0", in_ready, out_valid, c);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    issue(64'd100, 64'd7, DIV_DIVU, 1'b0, 64'd14);
    collect(64, 0, "first_after_reset");
  endtask

  task automatic test_backpressure();
    issue(64'd1000, 64'd7, DIV_DIVU, 1'b0, 64'd142);
    collect(64, 5, "backpressure");
  endtask

  task automatic test_early_out();
    int lat;
`ifdef DIV_EARLY_OUT_EN
    lat = 0;
`else
    lat = 64;
`endif
    issue(64'd3, 64'd5, DIV_DIVU, 1'b0, 64'd0);
    collect(lat, 0, "divu_3_5");
  endtask

  task automatic test_back_to_back();
    logic [63:0] x, y;
    divfunc_t f;
    logic w;
    for (int i = 0; i < 8; i++) begin
      x = {$urandom, $urandom};
      y = {$urandom, $urandom} >> $urandom_range(0, 63);
      f = divfunc_t'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      checks++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL b2b_ready%0d: in_ready=%0b required 1", i, in_ready);
      end
      issue(x, y, f, w, model(x, y, f, w));
      collect(-1, 0, $sformatf("b2b%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow();
    test_div_zero();
    test_word();
    test_flush();
    test_reset_midop();
    test_backpressure();
    test_early_out();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
